alu_arbiter: RTL
================

# alu_arbiter

Shares one ALU instance between up to four requesters: the on-board ALU tester, game/animation logic, and future sprite-update engines. It arbitrates round-robin, registers the winner's operands onto the ALU inputs, and waits a configurable ALU latency. It then returns the captured result to the winner with a one-cycle valid pulse. It sits between the requesters and the single ALU datapath in the top level.

## Interface
- N_REQ, 4: number of requesters, legal range 2..4
- WIDTH, 16: operand and result width
- FN_W, 6: ALU function-code width
- ALU_LAT, 1: cycles from ALU inputs changing to a valid result, legal range 1..15

- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  request per requester, level
- req_a  in  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B, same packing
- req_fn  in  N_REQ*FN_W  function code, requester i at [i*FN_W +: FN_W]
- gnt  out  N_REQ  one-hot grant, one-cycle pulse
- rsp_valid  out  N_REQ  one-hot result-ready, one-cycle pulse
- rsp_data  out  WIDTH  captured result, held until the next capture
- alu_a, alu_b  out  WIDTH  registered ALU operands
- alu_fn  out  FN_W  registered ALU function code
- alu_result  in  WIDTH  ALU output
- busy  out  1  high in WAIT

## Operation
- Reset values:
  - gnt=0, rsp_valid=0, rsp_data=0, alu_a=0, alu_b=0, alu_fn=0, busy=0.
  - state=IDLE, rr pointer=0, wait counter=0.
- IDLE:
  - If req is nonzero, pick the winner: the first set bit searching upward from the rr pointer and wrapping at N_REQ-1 to 0.
  - At the next edge: gnt[winner]=1, load alu_a/alu_b/alu_fn from the winner's slice, set rr pointer=(winner+1) mod N_REQ, counter=0, state=WAIT.
  - If req is zero, stay in IDLE with all outputs unchanged.
- WAIT:
  - busy=1; the counter increments each cycle.
  - On the cycle where counter==ALU_LAT-1, at the next edge: rsp_data<=alu_result, rsp_valid[winner]=1, state=IDLE.
  - req is ignored throughout WAIT.
- gnt and rsp_valid are forced back to 0 on the cycle after they assert.
- alu_a/alu_b/alu_fn hold their values in IDLE, so the ALU output stays stable between operations.
- Handshake:
  - A requester holds req and its operands stable until it sees its gnt bit high. Operands are sampled on the grant edge and may change afterwards.
  - Dropping req before the grant withdraws the request; no response follows.
  - If req is still high during the rsp_valid cycle, it counts as a new request, giving back-to-back service.
- Each requester has at most one outstanding operation; rsp_valid always targets the last granted index.
- Reset mid-operation aborts it: no rsp_valid is issued and the rr pointer returns to 0.
- Bits of req at index ≥ N_REQ do not exist. Operand slices of non-requesting inputs are don't-care.

## Timing
- If req is sampled high in IDLE at edge T, then gnt is high in cycle T+1 and rsp_valid is high in cycle T+1+ALU_LAT.
- alu_a/alu_b/alu_fn change at the grant edge and are stable through WAIT.
- Minimum grant-to-grant spacing is ALU_LAT+1 cycles. Peak throughput is one operation per ALU_LAT+1 cycles.
- Starvation bound: with all requesters continuously requesting, each is granted once every N_REQ grants.
- All outputs are registered; there is no combinational path from req to gnt.

## Configuration
- ALU_ARB_FIXED_PRI_EN:
  - When defined, requester 0 (the ALU tester) wins whenever req[0] is high, regardless of the rr pointer.
  - Requests without req[0] still use round-robin.
  - A grant to requester 0 leaves the rr pointer unchanged.
- When undefined, pure round-robin applies to all requesters, including 0.

## Test plan
- Single requester, ALU_LAT=1: req[2]=1 with a=0x0005, b=0x0003, fn=ADD, held until gnt.
  - gnt=0b0100 one cycle after the sampling edge.
  - alu_a=5, alu_b=3.
  - rsp_valid=0b0100 and rsp_data=0x0008 two cycles after sampling.
- Round-robin, all four req held high from reset:
  - Grant order is 0,1,2,3,0.
  - Consecutive grants are exactly ALU_LAT+1 cycles apart.
  - Each rsp_valid index matches its grant.
- Latency sweep, ALU_LAT=3, alu_result modelled as a 3-cycle delayed adder:
  - rsp_valid appears 4 cycles after the sampling edge with the correct sum.
  - busy is high for exactly 3 cycles.
- Withdrawal: req[1] and req[3] high together, then req[3] dropped during WAIT of the requester-1 operation.
  - No gnt[3] and no rsp_valid[3] follow.
  - The arbiter returns to IDLE with gnt=0.
- Reset mid-WAIT: assert rst_n=0 during WAIT.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - No rsp_valid after release.
  - The next grant goes to the lowest requesting index.
- ALU_ARB_FIXED_PRI_EN defined, req=0b1111 continuous:
  - Requester 0 is granted every time.
  - With req=0b1110, grant order is 1,2,3,1.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side bundle of the shared-ALU arbiter.
//   master : requester side  (drives req/req_a/req_b/req_fn, sees gnt/rsp_*)
//   slave  : arbiter side    (samples requests, returns gnt/rsp_valid/rsp_data)
// Operand and function slices are packed per requester: requester i owns
// req_a/req_b[i*WIDTH +: WIDTH] and req_fn[i*FN_W +: FN_W].
interface alu_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int FN_W  = 6
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ*FN_W-1:0]  req_fn;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_data;

  modport master (
    output req, req_a, req_b, req_fn,
    input  gnt, rsp_valid, rsp_data
  );

  modport slave (
    input  req, req_a, req_b, req_fn,
    output gnt, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between up to N_REQ requesters.
// Round-robin arbitration; the winner's operands are registered onto the ALU
// inputs, the arbiter waits ALU_LAT cycles, then captures the ALU result and
// returns it with a one-cycle rsp_valid pulse to the winner.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   bus (slave)       req/req_a/req_b/req_fn in, gnt/rsp_valid/rsp_data out
//   alu_a/alu_b/alu_fn registered ALU operands and function code
//   alu_result        ALU output, captured at the end of WAIT
//   busy              high while an operation is in flight
//
// Optional feature macro: ALU_ARB_FIXED_PRI_EN
//   Requester 0 wins whenever req[0] is high; such grants do not move the
//   round-robin pointer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no operation in flight; arbitrate among req on every edge
// ST_WAIT | operands on the ALU; counting ALU_LAT cycles to the result
module alu_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int FN_W    = 6,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [FN_W-1:0]  alu_fn,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = 4;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cur_idx;
  logic [CNT_W-1:0] cnt;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] rr_next;
  int               pos;

  // Walk from the highest rotated offset down to offset 0 so the last
  // assignment is the first requester at or above rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = int'(rr_ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (bus.req[pos]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(pos);
      end
    end
`ifdef ALU_ARB_FIXED_PRI_EN
    if (bus.req[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  assign rr_next = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      cur_idx       <= '0;
      cnt           <= '0;
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_fn        <= '0;
      busy          <= 1'b0;
    end else begin
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            bus.gnt <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            alu_a   <= bus.req_a[win_idx*WIDTH +: WIDTH];
            alu_b   <= bus.req_b[win_idx*WIDTH +: WIDTH];
            alu_fn  <= bus.req_fn[win_idx*FN_W +: FN_W];
            cur_idx <= win_idx;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ST_WAIT;
`ifdef ALU_ARB_FIXED_PRI_EN
            // Priority grants to requester 0 keep the rotation where it was.
            if (!bus.req[0]) rr_ptr <= rr_next;
`else
            rr_ptr <= rr_next;
`endif
          end
        end
        ST_WAIT: begin
          if (cnt == CNT_W'(ALU_LAT - 1)) begin
            bus.rsp_data  <= alu_result;
            bus.rsp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << cur_idx;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
